aes_key_expander_seq: RTL and testbench

- Sequential AES key-schedule generator.
- Sits directly upstream of the Cipher and InvCipher round engines and drives their keysContainer input.
- Replaces the fully combinational key generator with an iterative datapath: one 32-bit schedule word per clock, sharing 4 S-box lookups.
- Supports AES-128/192/256 through parameters and signals when the whole container is valid.

---
 rtl/aes_key_expander_seq.sv | 140 ++++++++++++++
 tb/tb_aes_key_expander_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander_seq.sv
// Iterative AES key-schedule generator: one 32-bit schedule word per clock,
// sharing a single 4-byte SubWord stage, for AES-128/192/256.
module aes_key_expander_seq #(
  parameter int NK = 4,
  parameter int NR = 10,
  localparam int NW = 4 * (NR + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [0:32*NK-1]  key,
  output logic              busy,
  output logic              keys_valid,
  output logic [0:32*NW-1]  keysContainer
);

  localparam int IW = $clog2(NW);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sboxByte(input logic [7:0] b);
    return SBOX_TABLE[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxByte(w[31:24]), sboxByte(w[23:16]), sboxByte(w[15:8]), sboxByte(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]    state_r;
  logic [IW-1:0] wordIdx_r;
  logic [3:0]    modCnt_r;
  logic [7:0]    rcon_r;
  // window_r[0] holds w[i-NK], window_r[NK-1] holds w[i-1]
  logic [31:0]   window_r [NK];

  logic [31:0] prevWord_s;
  logic [31:0] sboxIn_s;
  logic [31:0] subOut_s;
  logic [31:0] temp_s;
  logic [31:0] newWord_s;

  // Next schedule word from the sliding window and the shared SubWord stage
  always_comb begin
    prevWord_s = window_r[NK-1];
    if (modCnt_r == 4'd0) begin
      sboxIn_s = {prevWord_s[23:0], prevWord_s[31:24]};
    end else begin
      sboxIn_s = prevWord_s;
    end
    subOut_s = subWord(sboxIn_s);
    if (modCnt_r == 4'd0) begin
      temp_s = subOut_s ^ {rcon_r, 24'h000000};
    end else if ((NK == 8) && (modCnt_r == 4'd4)) begin
      temp_s = subOut_s;
    end else begin
      temp_s = prevWord_s;
    end
    newWord_s = window_r[0] ^ temp_s;
  end

  // Control FSM, schedule window and output container
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      busy          <= 1'b0;
      keys_valid    <= 1'b0;
      keysContainer <= {(32*NW){1'b0}};
      wordIdx_r     <= {IW{1'b0}};
      modCnt_r      <= 4'd0;
      rcon_r        <= 8'h01;
      for (int j = 0; j < NK; j++) begin
        window_r[j] <= 32'h00000000;
      end
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            for (int j = 0; j < NK; j++) begin
              keysContainer[32*j +: 32] <= key[32*j +: 32];
              window_r[j]               <= key[32*j +: 32];
            end
            wordIdx_r  <= IW'(NK);
            modCnt_r   <= 4'd0;
            rcon_r     <= 8'h01;
            state_r    <= EXPAND;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        EXPAND: begin
          keysContainer[32*int'(wordIdx_r) +: 32] <= newWord_s;
          for (int j = 0; j < NK - 1; j++) begin
            window_r[j] <= window_r[j+1];
          end
          window_r[NK-1] <= newWord_s;
          if (modCnt_r == 4'd0) begin
            rcon_r <= xtime(rcon_r);
          end
          if (modCnt_r == 4'(NK - 1)) begin
            modCnt_r <= 4'd0;
          end else begin
            modCnt_r <= modCnt_r + 4'd1;
          end
          if (wordIdx_r == IW'(NW - 1)) begin
            state_r    <= DONE;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end else begin
            wordIdx_r <= wordIdx_r + IW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          keys_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Scoreboard bench for aes_key_expander_seq: AES-128/192/256 instances checked
// against a reference schedule built from GF(2^8) arithmetic.
module tb_aes_key_expander_seq;

  typedef logic [0:1919] cont_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic start4, start6, start8;
  logic [0:127] key4;
  logic [0:191] key6;
  logic [0:255] key8;
  logic busy4, busy6, busy8, valid4, valid6, valid8;
  logic [0:1407] cont4;
  logic [0:1663] cont6;
  logic [0:1919] cont8;

  aes_key_expander_seq #(.NK(4), .NR(10)) dut4 (.clk(clk), .reset(reset), .start(start4),
    .key(key4), .busy(busy4), .keys_valid(valid4), .keysContainer(cont4));
  aes_key_expander_seq #(.NK(6), .NR(12)) dut6 (.clk(clk), .reset(reset), .start(start6),
    .key(key6), .busy(busy6), .keys_valid(valid6), .keysContainer(cont6));
  aes_key_expander_seq #(.NK(8), .NR(14)) dut8 (.clk(clk), .reset(reset), .start(start8),
    .key(key8), .busy(busy8), .keys_valid(valid8), .keysContainer(cont8));

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sboxTab [256];
  cont_t expQ4[$], expQ6[$], expQ8[$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] refSub(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  // FIPS-197 key expansion written directly as word arithmetic
  function automatic cont_t refExpand(input logic [0:255] k, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    cont_t r = '0;
    int nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = refSub({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = refSub(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [0:255] randKey();
    logic [0:255] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCont(input string name, input cont_t act, input cont_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      for (int i = 0; i < 60; i++) begin
        if (act[32*i +: 32] !== exp[32*i +: 32]) begin
          $display("FAIL %s: word %0d got %h, expected %h", name, i, act[32*i +: 32], exp[32*i +: 32]);
          break;
        end
      end
    end
  endtask

  task automatic startDut(input int which, input logic [0:255] k);
    @(negedge clk);
    if (which == 4) begin
      key4 = k[0:127]; start4 = 1'b1; expQ4.push_back(refExpand(k, 4));
    end else if (which == 6) begin
      key6 = k[0:191]; start6 = 1'b1; expQ6.push_back(refExpand(k, 6));
    end else begin
      key8 = k; start8 = 1'b1; expQ8.push_back(refExpand(k, 8));
    end
    @(negedge clk);
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
  endtask

  task automatic waitValid(input int which);
    logic seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = (which == 4) ? valid4 : (which == 6) ? valid6 : valid8;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid%0d: keys_valid=0 after 200 cycles, expected 1", which);
    end
  endtask

  // Monitors: busy length and full container checked on each keys_valid rise
  initial begin
    int cnt; logic pv; cnt = 0; pv = 1'b0;
    forever begin
      @(negedge clk);
      if (busy4) cnt++;
      if (valid4 && !pv) begin
        checkVal("busy4_cycles", 128'(cnt), 128'd40);
        if (expQ4.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL cont4: valid with no pending request");
        end else checkCont("cont4", {cont4, 512'b0}, expQ4.pop_front());
        cnt = 0;
      end
      if (!busy4 && !valid4) cnt = 0;
      pv = valid4;
    end
  end

  initial begin
    int cnt; logic pv; cnt = 0; pv = 1'b0;
    forever begin
      @(negedge clk);
      if (busy6) cnt++;
      if (valid6 && !pv) begin
        checkVal("busy6_cycles", 128'(cnt), 128'd46);
        if (expQ6.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL cont6: valid with no pending request");
        end else checkCont("cont6", {cont6, 256'b0}, expQ6.pop_front());
        cnt = 0;
      end
      if (!busy6 && !valid6) cnt = 0;
      pv = valid6;
    end
  end

  initial begin
    int cnt; logic pv; cnt = 0; pv = 1'b0;
    forever begin
      @(negedge clk);
      if (busy8) cnt++;
      if (valid8 && !pv) begin
        checkVal("busy8_cycles", 128'(cnt), 128'd52);
        if (expQ8.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL cont8: valid with no pending request");
        end else checkCont("cont8", cont8, expQ8.pop_front());
        cnt = 0;
      end
      if (!busy8 && !valid8) cnt = 0;
      pv = valid8;
    end
  end

  logic [0:255] fips128, keyA, keyB;

  initial begin
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256 && b != 0; x++) begin
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sboxTab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    fips128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    #1 reset = 1'b1;
    #1;
    checkVal("rst_busy", 128'({busy4, busy6, busy8}), 128'd0);
    checkVal("rst_valid", 128'({valid4, valid6, valid8}), 128'd0);
    checkVal("rst_cont", 128'({|cont4, |cont6, |cont8}), 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    startDut(4, fips128);
    waitValid(4);
    checkVal("aes128_w4", 128'(cont4[32*4 +: 32]), 128'h a0fafe17);
    checkVal("aes128_w43", 128'(cont4[32*43 +: 32]), 128'h b6630ca6);

    startDut(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    waitValid(4);
    checkVal("aes128_rk10", cont4[32*40 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    startDut(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    waitValid(6);
    checkVal("aes192_w51", 128'(cont6[32*51 +: 32]), 128'h01002202);

    startDut(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    waitValid(8);
    checkVal("aes256_w59", 128'(cont8[32*59 +: 32]), 128'h706c631e);

    startDut(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    waitValid(8);
    checkVal("aes256_rk14", cont8[32*56 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Second start and key change mid-expansion must be ignored
    startDut(4, fips128);
    repeat (9) @(negedge clk);
    key4 = randKey(); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; key4 = randKey();
    waitValid(4);
    checkVal("ignored_w43", 128'(cont4[32*43 +: 32]), 128'h b6630ca6);

    // Asynchronous reset in the middle of an expansion
    startDut(4, fips128);
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkVal("midrst_busy", 128'(busy4), 128'd0);
    checkVal("midrst_valid", 128'(valid4), 128'd0);
    checkVal("midrst_cont", 128'(|cont4), 128'd0);
    expQ4.delete(); expQ6.delete(); expQ8.delete();
    @(negedge clk);
    reset = 1'b0;
    startDut(4, fips128);
    waitValid(4);
    checkVal("restart_w43", 128'(cont4[32*43 +: 32]), 128'h b6630ca6);

    // Re-start from DONE with a new key
    keyA = randKey();
    startDut(4, keyA);
    checkVal("redo_valid_drop", 128'(valid4), 128'd0);
    checkVal("redo_busy", 128'(busy4), 128'd1);
    waitValid(4);

    for (int n = 0; n < 4; n++) begin
      keyA = randKey(); keyB = randKey();
      startDut(4, keyA);
      startDut(6, keyB);
      startDut(8, randKey());
      waitValid(8); waitValid(6); waitValid(4);
    end

    repeat (3) @(negedge clk);
    checkVal("q4_drained", 128'(expQ4.size()), 128'd0);
    checkVal("q6_drained", 128'(expQ6.size()), 128'd0);
    checkVal("q8_drained", 128'(expQ8.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
